regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-back arbiter between multiple result producers and the two write ports (E and M) of the 6-entry register file. Each cycle it accepts up to two valid/ready write requests in round-robin order, never grants two writes to the same register in one cycle, and drives registered `dstE/valE` and `dstM/valM` to the register file one cycle after grant. Requests to non-existent registers are accepted and discarded, and a saturating counter records them.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `DW`, 32: data width.
- `AW`, 4: register ID width.
- `NREG`, 6: number of implemented registers; valid IDs are 0..NREG-1.
- `NOWR`, 4'hF: ID driven on an idle write port. It must be ≥ NREG.

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  when low, no grants are issued. Outputs go idle on the next edge.
- `req_valid`  in  NREQ  per-requester write request.
- `req_dst`  in  NREQ*AW  packed destination IDs; requester i occupies [i*AW +: AW].
- `req_data`  in  NREQ*DW  packed write data.
- `req_ready`  out  NREQ  grant. Combinational from valid, dst, pointer and enable.
- `dstE`, `valE`  out  AW, DW  registered E-port write.
- `dstM`, `valM`  out  AW, DW  registered M-port write.
- `wr_mask`  out  NREG  registered; bit r is high when E or M writes r this cycle.
- `drop_cnt`  out  8  saturating count of accepted requests with an invalid ID.

## Operation
- **Transfer rule.** A transfer occurs on requester i when `req_valid[i] && req_ready[i]` at a rising edge. Requesters hold valid, dst and data stable until the transfer. `req_ready[i]` is never high while `req_valid[i]` is low.
- **Round-robin scan.** A pointer `ptr` (0..NREQ-1) selects the highest-priority requester. The scan order is ptr, ptr+1, …, wrapping modulo NREQ.
- **Grant selection.** With `enable` high, the scan grants at most two requesters:
  - The first valid requester with a valid ID (dst < NREG) is granted to port E.
  - The next valid requester whose valid ID differs from E's is granted to port M.
  - A later requester with the same ID as E is not granted and stays pending.
- **Invalid IDs.** A valid requester with dst ≥ NREG is always granted in the same cycle (it consumes no port). Its data is discarded and `drop_cnt` increments by the number of such transfers this cycle, saturating at 255.
- **Pointer update.** After any transfer with a valid ID, `ptr` becomes (index of the last port-granted requester + 1) mod NREQ. With no valid-ID grants, `ptr` is unchanged.
- **Port registers.** On each edge:
  - `dstE`/`valE` load the E-granted requester's dst/data, or `NOWR`/0 if none.
  - `dstM`/`valM` load the same for the M grant.
  - `wr_mask` is the one-hot OR of the loaded valid IDs.
- **Port invariant.** `dstE == dstM` with both < NREG never occurs.
- **Enable low.** All `req_ready` are low and nothing is dropped. Ports load `NOWR`/0.

## Timing
- **Reset values.** Asynchronous assert with `reset_n` low sets:
  - `dstE = dstM = NOWR`, `valE = valM = 0`
  - `wr_mask = 0`, `drop_cnt = 0`, `ptr = 0`
  
  While reset is asserted, `req_ready` is 0. The first grant is possible in the first cycle after deassertion.
- **Latency.** A grant at edge t drives the regfile port during cycle t→t+1. The register file commits at edge t+1, so read-back through `valA`/`valB` appears at edge t+2.
- **Throughput.** Up to 2 register writes per cycle plus any number of drops.
- **Mid-operation reset.** Pending requests are not granted. Port outputs go idle immediately (asynchronously) and no partial write reaches the register file after the reset edge.
- **Pointer wrap.** When the last port grant is index NREQ-1, `ptr` wraps to 0.

## Test plan
- **Basic grant.** Reset, then one request: req0 dst=2 data=32'hA5A5_0001 valid for 1 cycle.
  - Expect `req_ready[0]` high that cycle.
  - Next cycle: dstE=2, valE=A5A5_0001, dstM=F, wr_mask=6'b000100, then idle.
- **Dual grant with conflict.** With ptr=0, req0 dst=1, req1 dst=1, req2 dst=3 all valid.
  - Cycle 1: ready=0101; ports E(1, req0 data), M(3, req2 data); ptr→3.
  - Cycle 2: req1 granted to E.
- **Fairness.** All 4 requesters hold valid with distinct dst 0..3 for 4 cycles.
  - Grants alternate {0,1}, {2,3}, {0,1}, {2,3}.
  - ptr wraps 0→2→0.
- **Drops.** req3 dst=7 valid for 300 cycles.
  - `req_ready[3]` is high every cycle and ports stay idle.
  - `drop_cnt` reaches 255 and holds there.
- **Enable and reset.**
  - `enable` low for 3 cycles with requests pending: no ready, ports idle.
  - Pulse `reset_n` low mid-cycle while dstE=4 is driven: dstE=F immediately and `drop_cnt` clears to 0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: a round-robin scan grants up to two distinct-register writes per cycle
// to the E and M register-file ports; writes to unimplemented registers are accepted and dropped.
module regfile_wb_arbiter #(
  parameter int            NREQ = 4,
  parameter int            DW   = 32,
  parameter int            AW   = 4,
  parameter int            NREG = 6,
  parameter logic [AW-1:0] NOWR = 4'hF
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_dst,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic [AW-1:0]      dstE,
  output logic [DW-1:0]      valE,
  output logic [AW-1:0]      dstM,
  output logic [DW-1:0]      valM,
  output logic [NREG-1:0]    wr_mask,
  output logic [7:0]         drop_cnt
);
  localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PW1 = PW + 1;

  logic [PW-1:0]   ptr, next_ptr, idx, e_idx, m_idx, last_idx;
  logic [PW:0]     idx_sum, last_sum;
  logic [AW-1:0]   cur_dst, e_dst, m_dst;
  logic            e_found, m_found, scan_on;
  logic [3:0]      drop_now;
  logic [8:0]      drop_sum;
  logic [NREG-1:0] mask_next;

  // Scan from ptr: invalid IDs are always accepted, the first valid ID takes E and the
  // next valid ID naming a different register takes M; same-register requests wait.
  always_comb begin
    req_ready = '0;
    e_found   = 1'b0;
    m_found   = 1'b0;
    e_idx     = '0;
    m_idx     = '0;
    e_dst     = NOWR;
    m_dst     = NOWR;
    drop_now  = '0;
    idx_sum   = '0;
    idx       = '0;
    cur_dst   = '0;
    scan_on   = enable && reset_n;
    for (int k = 0; k < NREQ; k++) begin
      idx_sum = {1'b0, ptr} + PW1'(k);
      if (idx_sum >= PW1'(NREQ)) idx_sum = idx_sum - PW1'(NREQ);
      idx     = idx_sum[PW-1:0];
      cur_dst = req_dst[idx*AW +: AW];
      if (scan_on && req_valid[idx]) begin
        if (cur_dst >= AW'(NREG)) begin
          req_ready[idx] = 1'b1;
          drop_now       = drop_now + 4'd1;
        end else if (!e_found) begin
          req_ready[idx] = 1'b1;
          e_found        = 1'b1;
          e_idx          = idx;
          e_dst          = cur_dst;
        end else if (!m_found && (cur_dst != e_dst)) begin
          req_ready[idx] = 1'b1;
          m_found        = 1'b1;
          m_idx          = idx;
          m_dst          = cur_dst;
        end
      end
    end
  end

  always_comb begin
    last_idx  = m_found ? m_idx : e_idx;
    last_sum  = {1'b0, last_idx} + PW1'(1);
    next_ptr  = (last_sum >= PW1'(NREQ)) ? '0 : last_sum[PW-1:0];
    drop_sum  = {1'b0, drop_cnt} + 9'(drop_now);
    mask_next = '0;
    for (int r = 0; r < NREG; r++) begin
      mask_next[r] = (e_found && (e_dst == AW'(r))) || (m_found && (m_dst == AW'(r)));
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr      <= '0;
      dstE     <= NOWR;
      valE     <= '0;
      dstM     <= NOWR;
      valM     <= '0;
      wr_mask  <= '0;
      drop_cnt <= '0;
    end else begin
      dstE     <= e_found ? e_dst : NOWR;
      valE     <= e_found ? req_data[e_idx*DW +: DW] : '0;
      dstM     <= m_found ? m_dst : NOWR;
      valM     <= m_found ? req_data[m_idx*DW +: DW] : '0;
      wr_mask  <= mask_next;
      drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      if (e_found) ptr <= next_ptr;
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter, checked every cycle against
// a scan-order reference model of the grant rules.
module tb_regfile_wb_arbiter;
  localparam int            NREQ = 4;
  localparam int            DW   = 32;
  localparam int            AW   = 4;
  localparam int            NREG = 6;
  localparam logic [AW-1:0] NOWR = 4'hF;

  typedef struct {
    int              e;
    int              m;
    logic [NREQ-1:0] ready;
    int              drops;
  } grant_t;

  logic               clock = 1'b0;
  logic               reset_n = 1'b0;
  logic               enable = 1'b1;
  logic [NREQ-1:0]    tvalid = '0;
  int                 tdst[NREQ];
  logic [DW-1:0]      tdata[NREQ];
  logic [NREQ*AW-1:0] req_dst;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic [AW-1:0]      dstE, dstM;
  logic [DW-1:0]      valE, valM;
  logic [NREG-1:0]    wr_mask;
  logic [7:0]         drop_cnt;
  logic [NREQ-1:0]    hs_snap = '0;
  bit                 auto_release = 1'b1;

  int              checks = 0;
  int              failures = 0;
  int              exp_ptr = 0;
  int              exp_dst_e = 15;
  int              exp_dst_m = 15;
  logic [DW-1:0]   exp_val_e = '0;
  logic [DW-1:0]   exp_val_m = '0;
  logic [NREG-1:0] exp_mask = '0;
  int              exp_drop = 0;

  regfile_wb_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW), .NREG(NREG), .NOWR(NOWR)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable),
    .req_valid(tvalid), .req_dst(req_dst), .req_data(req_data), .req_ready(req_ready),
    .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM),
    .wr_mask(wr_mask), .drop_cnt(drop_cnt)
  );

  always #5 clock = ~clock;

  always_comb begin
    req_dst  = '0;
    req_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_dst[i*AW +: AW]  = AW'(tdst[i]);
      req_data[i*DW +: DW] = tdata[i];
    end
  end

  // Reference grant rules: walk requesters in priority order starting at p.
  function automatic grant_t arbitrate(int p, logic en, logic [NREQ-1:0] v, int d[NREQ]);
    grant_t g;
    g.e = -1; g.m = -1; g.ready = '0; g.drops = 0;
    if (!en) return g;
    for (int k = 0; k < NREQ; k++) begin
      int i = (p + k) % NREQ;
      if (v[i]) begin
        if (d[i] >= NREG) begin
          g.ready[i] = 1'b1;
          g.drops++;
        end else if (g.e < 0) begin
          g.e = i;
          g.ready[i] = 1'b1;
        end else if (g.m < 0 && d[i] != d[g.e]) begin
          g.m = i;
          g.ready[i] = 1'b1;
        end
      end
    end
    return g;
  endfunction

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model of the registered ports, pointer and drop counter.
  always @(posedge clock or negedge reset_n) begin
    grant_t g;
    int last, nd;
    logic [NREG-1:0] m;
    if (!reset_n) begin
      exp_ptr   <= 0;
      exp_dst_e <= 15;
      exp_dst_m <= 15;
      exp_val_e <= '0;
      exp_val_m <= '0;
      exp_mask  <= '0;
      exp_drop  <= 0;
    end else begin
      g = arbitrate(exp_ptr, enable, tvalid, tdst);
      m = '0;
      if (g.e >= 0) begin
        exp_dst_e <= tdst[g.e];
        exp_val_e <= tdata[g.e];
        m[tdst[g.e]] = 1'b1;
      end else begin
        exp_dst_e <= 15;
        exp_val_e <= '0;
      end
      if (g.m >= 0) begin
        exp_dst_m <= tdst[g.m];
        exp_val_m <= tdata[g.m];
        m[tdst[g.m]] = 1'b1;
      end else begin
        exp_dst_m <= 15;
        exp_val_m <= '0;
      end
      exp_mask <= m;
      nd = exp_drop + g.drops;
      exp_drop <= (nd > 255) ? 255 : nd;
      last = (g.m >= 0) ? g.m : g.e;
      if (last >= 0) exp_ptr <= (last + 1) % NREQ;
    end
  end

  always @(negedge clock) hs_snap <= tvalid & req_ready;

  // Every-cycle comparison against the model.
  always @(negedge clock) begin
    grant_t g;
    g = arbitrate(exp_ptr, enable && reset_n, tvalid, tdst);
    check_output("req_ready", 64'(req_ready), 64'(g.ready));
    check_output("dstE", 64'(dstE), 64'(exp_dst_e));
    check_output("valE", 64'(valE), 64'(exp_val_e));
    check_output("dstM", 64'(dstM), 64'(exp_dst_m));
    check_output("valM", 64'(valM), 64'(exp_val_m));
    check_output("wr_mask", 64'(wr_mask), 64'(exp_mask));
    check_output("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
    check_output("port_conflict", 64'(dstE == dstM && dstE < NREG), 64'd0);
  end

  task automatic do_reset();
    reset_n = 1'b0;
    tvalid  = '0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
    if (auto_release) tvalid = tvalid & ~hs_snap;
  endtask

  task automatic wait_negedge();
    @(negedge clock);
    #1;
  endtask

  task automatic apply_stimulus(input int i, input int d, input logic [DW-1:0] data);
    tdst[i]   = d;
    tdata[i]  = data;
    tvalid[i] = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      tdst[i]  = 0;
      tdata[i] = '0;
    end
    do_reset();

    // Basic grant
    apply_stimulus(0, 2, 32'hA5A5_0001);
    wait_negedge();
    check_output("basic_ready", 64'(req_ready), 64'h1);
    next_cycle();
    wait_negedge();
    check_output("basic_dstE", 64'(dstE), 64'h2);
    check_output("basic_valE", 64'(valE), 64'hA5A5_0001);
    check_output("basic_dstM", 64'(dstM), 64'hF);
    check_output("basic_mask", 64'(wr_mask), 64'b000100);
    next_cycle();
    wait_negedge();
    check_output("basic_idle", 64'(dstE), 64'hF);

    // Dual grant with same-register conflict
    do_reset();
    apply_stimulus(0, 1, 32'h1111_0000);
    apply_stimulus(1, 1, 32'h1111_0001);
    apply_stimulus(2, 3, 32'h3333_0002);
    wait_negedge();
    check_output("dual_ready1", 64'(req_ready), 64'b0101);
    next_cycle();
    wait_negedge();
    check_output("dual_dstE", 64'(dstE), 64'h1);
    check_output("dual_valE", 64'(valE), 64'h1111_0000);
    check_output("dual_dstM", 64'(dstM), 64'h3);
    check_output("dual_valM", 64'(valM), 64'h3333_0002);
    check_output("dual_ready2", 64'(req_ready), 64'b0010);
    next_cycle();
    wait_negedge();
    check_output("dual_pending_valE", 64'(valE), 64'h1111_0001);

    // Fairness with four held requests
    do_reset();
    auto_release = 1'b0;
    for (int i = 0; i < NREQ; i++) apply_stimulus(i, i, 32'hF000_0000 + 32'(i));
    for (int c = 0; c < 4; c++) begin
      wait_negedge();
      check_output("fair_ready", 64'(req_ready), (c % 2 == 0) ? 64'b0011 : 64'b1100);
      next_cycle();
    end
    tvalid = '0;

    // Drops saturate at 255
    do_reset();
    apply_stimulus(3, 7, 32'hDEAD_BEEF);
    wait_negedge();
    check_output("drop_ready", 64'(req_ready), 64'b1000);
    repeat (300) next_cycle();
    wait_negedge();
    check_output("drop_sat", 64'(drop_cnt), 64'd255);
    check_output("drop_idle", 64'(dstE), 64'hF);
    tvalid = '0;
    auto_release = 1'b1;

    // Enable low, then mid-cycle reset
    do_reset();
    enable = 1'b0;
    apply_stimulus(0, 4, 32'h4444_4444);
    apply_stimulus(1, 5, 32'h5555_5555);
    apply_stimulus(2, 9, 32'h9999_9999);
    repeat (3) begin
      wait_negedge();
      check_output("en_low_ready", 64'(req_ready), 64'h0);
      check_output("en_low_dstE", 64'(dstE), 64'hF);
      next_cycle();
    end
    enable = 1'b1;
    wait_negedge();
    check_output("en_high_ready", 64'(req_ready), 64'b0111);
    next_cycle();
    #1;
    check_output("pre_reset_dstE", 64'(dstE), 64'h4);
    check_output("pre_reset_drop", 64'(drop_cnt), 64'd1);
    #1 reset_n = 1'b0;
    #1;
    check_output("async_dstE", 64'(dstE), 64'hF);
    check_output("async_dstM", 64'(dstM), 64'hF);
    check_output("async_drop", 64'(drop_cnt), 64'd0);
    check_output("async_mask", 64'(wr_mask), 64'd0);
    #2 reset_n = 1'b1;
    next_cycle();

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!tvalid[i] && $urandom_range(0, 1) == 1)
          apply_stimulus(i, $urandom_range(0, 7), $urandom);
      end
      enable = ($urandom_range(0, 9) != 0);
      next_cycle();
    end
    enable = 1'b1;
    tvalid = '0;
    repeat (2) next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
